// File: rtl/pkt_rx_pkg.sv
// Shared types for the packet-interface receive drain: FSM encoding, summary record,
// and the eop mod-to-bytecount helper.
package pkt_rx_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_READ    = ST_READ,
        S_DISCARD = ST_DISCARD,
        S_HOLD    = ST_HOLD
    } state_e;

    typedef struct packed {
        logic [15:0] len;
        logic [31:0] bytes;
        logic        mac_err;
        logic        no_sop;
        logic        early_sop;
        logic        timeout;
        logic        oversize;
    } sum_rec_t;

    // A mod of 0 on the eop word means the whole word is valid.
    function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/pkt_byte_acc.sv
// Per-word accumulator: masks the valid leading bytes of a 64-bit word and adds them
// to a running saturating length and a wrap-around byte sum.
module pkt_byte_acc
    import pkt_rx_pkg::*;
(
    input  logic [63:0] data,
    input  logic        eop,
    input  logic [2:0]  mod,
    input  logic [15:0] len_in,
    input  logic [31:0] sum_in,
    output logic [15:0] len_out,
    output logic [31:0] sum_out
);

    logic [3:0]  nbytes;
    logic [31:0] word_sum;
    logic [16:0] len_wide;

    always_comb begin
        nbytes   = eop ? mod_to_bytes(mod) : 4'd8;
        word_sum = '0;
        // Byte 0 of the frame sits in the top lane, so the mask grows downward.
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                word_sum = word_sum + 32'(data[63-8*i -: 8]);
            end
        end
        len_wide = {1'b0, len_in} + 17'(nbytes);
        len_out  = len_wide[16] ? 16'hFFFF : len_wide[15:0];
        sum_out  = sum_in + word_sum;
    end

endmodule

// File: rtl/pkt_rx_drain.sv
// Receive drain on the MAC pkt_rx side: reads whole frames, checks framing, and emits one
// summary record per frame. Optional counters enabled by PKT_RX_DRAIN_STATS_EN.
module pkt_rx_drain
    import pkt_rx_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int TIMEOUT = 64
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        enable,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [15:0] sum_len,
    output logic [31:0] sum_bytes,
    output logic        sum_mac_err,
    output logic        sum_no_sop,
    output logic        sum_early_sop,
    output logic        sum_timeout,
    output logic        sum_oversize
`ifdef PKT_RX_DRAIN_STATS_EN
    ,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_errors
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    sum_rec_t         rec_q, rec_d;
    logic             started_q, started_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [15:0] base_len, acc_len;
    logic [31:0] base_sum, acc_sum;

    // A sop word always restarts the accumulation from zero.
    assign base_len = pkt_rx_sop ? 16'd0 : rec_q.len;
    assign base_sum = pkt_rx_sop ? 32'd0 : rec_q.bytes;

    pkt_byte_acc u_acc (
        .data    (pkt_rx_data),
        .eop     (pkt_rx_eop),
        .mod     (pkt_rx_mod),
        .len_in  (base_len),
        .sum_in  (base_sum),
        .len_out (acc_len),
        .sum_out (acc_sum)
    );

    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        started_d  = started_q;
        tmo_d      = tmo_q;
        pkt_rx_ren = 1'b0;
        case (state_q)
            S_IDLE: begin
                rec_d     = '0;
                started_d = 1'b0;
                tmo_d     = '0;
                if (enable && pkt_rx_avail) state_d = S_READ;
            end
            S_READ, S_DISCARD: begin
                // Never request past eop: the MAC would hand over the next frame's head.
                pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop);
                if (pkt_rx_val) begin
                    tmo_d = '0;
                    if (pkt_rx_err) rec_d.mac_err = 1'b1;
                    if (state_q == S_DISCARD) begin
                        if (pkt_rx_eop) state_d = S_HOLD;
                    end else if (pkt_rx_sop) begin
                        if (started_q) rec_d.early_sop = 1'b1;
                        started_d   = 1'b1;
                        rec_d.len   = acc_len;
                        rec_d.bytes = acc_sum;
                        if (pkt_rx_eop) state_d = S_HOLD;
                    end else if (!started_q) begin
                        rec_d.no_sop = 1'b1;
                        state_d      = pkt_rx_eop ? S_HOLD : S_DISCARD;
                    end else begin
                        rec_d.len   = acc_len;
                        rec_d.bytes = acc_sum;
                        if (pkt_rx_eop) state_d = S_HOLD;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_W'(TIMEOUT)) begin
                        rec_d.timeout = 1'b1;
                        state_d       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (sum_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_HOLD && state_d == S_HOLD) begin
            rec_d.oversize = (32'(rec_d.len) > 32'(MAX_LEN));
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q   <= S_IDLE;
            rec_q     <= '0;
            started_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            started_q <= started_d;
            tmo_q     <= tmo_d;
        end
    end

    assign sum_valid     = (state_q == S_HOLD);
    assign sum_len       = rec_q.len;
    assign sum_bytes     = rec_q.bytes;
    assign sum_mac_err   = rec_q.mac_err;
    assign sum_no_sop    = rec_q.no_sop;
    assign sum_early_sop = rec_q.early_sop;
    assign sum_timeout   = rec_q.timeout;
    assign sum_oversize  = rec_q.oversize;

`ifdef PKT_RX_DRAIN_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d;
    logic [31:0] stat_errors_q, stat_errors_d;
    logic        any_err;

    assign any_err = rec_q.mac_err | rec_q.no_sop | rec_q.early_sop | rec_q.timeout | rec_q.oversize;

    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_errors_d = stat_errors_q;
        if (sum_valid && sum_ready) begin
            stat_frames_d = stat_frames_q + 32'd1;
            if (any_err) stat_errors_d = stat_errors_q + 32'd1;
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            stat_frames_q <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_pkt_rx_drain.sv
// Directed bench for pkt_rx_drain: a table of frame scenarios plus hand sequences for
// early sop, enable gating, backpressure and mid-frame reset.
module tb_pkt_rx_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        avail;
    logic        ren;
    logic [63:0] data;
    logic        val, sop, eop, err;
    logic [2:0]  mod;
    logic        sum_valid, sum_ready;
    logic [15:0] sum_len;
    logic [31:0] sum_bytes;
    logic        f_mac, f_nosop, f_esop, f_tmo, f_over;
`ifdef PKT_RX_DRAIN_STATS_EN
    logic [31:0] stat_frames, stat_errors;
`endif

    always #5 clk = ~clk;

    pkt_rx_drain #(.MAX_LEN(1518), .TIMEOUT(64)) dut (
        .clk_156m25    (clk),
        .reset_156m25  (reset),
        .enable        (enable),
        .pkt_rx_avail  (avail),
        .pkt_rx_ren    (ren),
        .pkt_rx_data   (data),
        .pkt_rx_val    (val),
        .pkt_rx_sop    (sop),
        .pkt_rx_eop    (eop),
        .pkt_rx_mod    (mod),
        .pkt_rx_err    (err),
        .sum_valid     (sum_valid),
        .sum_ready     (sum_ready),
        .sum_len       (sum_len),
        .sum_bytes     (sum_bytes),
        .sum_mac_err   (f_mac),
        .sum_no_sop    (f_nosop),
        .sum_early_sop (f_esop),
        .sum_timeout   (f_tmo),
        .sum_oversize  (f_over)
`ifdef PKT_RX_DRAIN_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_errors   (stat_errors)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef struct {
        int          nbytes;
        bit          sop_first;
        bit          err_eop;
        int          stall_after;
        logic [15:0] exp_len;
        logic [31:0] exp_sum;
        logic [4:0]  exp_flags;   // {mac_err, no_sop, early_sop, timeout, oversize}
    } vec_t;

    word_t fq[$];
    int    gidx;
    int    checks, errors;
    int    exp_frames, exp_errs;
    logic [4:0] flags;

    assign flags = {f_mac, f_nosop, f_esop, f_tmo, f_over};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame byte k carries (k+1) mod 256; unused eop lanes carry 0xEE.
    task automatic build_frame(input int nbytes, input bit sop_first, input bit err_eop);
        word_t w;
        int    nw;
        fq.delete();
        gidx = 0;
        nw   = (nbytes + 7) / 8;
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                int k;
                k = j * 8 + b;
                w.d[63-8*b -: 8] = (k < nbytes) ? 8'((k + 1) % 256) : 8'hEE;
            end
            w.sop = (j == 0) && sop_first;
            w.eop = (j == nw - 1);
            w.mod = w.eop ? 3'(nbytes % 8) : 3'd0;
            w.err = w.eop && err_eop;
            fq.push_back(w);
        end
    endtask

    task automatic drive_word(input word_t w);
        val = 1'b1; data = w.d; sop = w.sop; eop = w.eop; mod = w.mod; err = w.err;
    endtask

    task automatic idle_word();
        val = 1'b0; data = '0; sop = 1'b0; eop = 1'b0; mod = '0; err = 1'b0;
    endtask

    // MAC responder: answers each ren with the next queued word one cycle later.
    task automatic run_frame(input int stall_after, input string tag);
        int cyc, eop_cyc, last_val_cyc, first_ren;
        bit pend, done;
        pend = 1'b0; done = 1'b0; cyc = 0; eop_cyc = -1; last_val_cyc = -1; first_ren = -1;
        avail = 1'b1;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            if (pend && gidx < fq.size() && (stall_after < 0 || gidx < stall_after)) begin
                drive_word(fq[gidx]);
                if (fq[gidx].eop) eop_cyc = cyc;
                last_val_cyc = cyc;
                gidx++;
            end else begin
                idle_word();
            end
            #1;
            if (val && eop) chk({tag, "_ren_at_eop"}, {31'd0, ren}, 32'd0);
            if (ren && first_ren < 0) begin
                first_ren = cyc;
                avail     = 1'b0;
                enable    = 1'b0;   // must not abort the frame in progress
            end
            pend = ren;
            if (sum_valid) done = 1'b1;
            else cyc++;
        end
        idle_word();
        enable = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_valid_wait: sum_valid absent after %0d cycles", tag, cyc);
        end else begin
            chk({tag, "_ren_latency"}, first_ren, 32'd0);
            if (stall_after < 0) chk({tag, "_valid_after_eop"}, cyc - eop_cyc, 32'd1);
            else chk({tag, "_tmo_cycles"}, cyc - last_val_cyc, 32'd65);
        end
    endtask

    task automatic check_sum(input string tag, input logic [15:0] l, input logic [31:0] s,
                             input logic [4:0] f);
        chk({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
        chk({tag, "_len"}, {16'd0, sum_len}, {16'd0, l});
        chk({tag, "_bytes"}, sum_bytes, s);
        chk({tag, "_flags"}, {27'd0, flags}, {27'd0, f});
    endtask

    task automatic check_stats(input string tag);
`ifdef PKT_RX_DRAIN_STATS_EN
        chk({tag, "_stat_frames"}, stat_frames, exp_frames);
        chk({tag, "_stat_errors"}, stat_errors, exp_errs);
`else
        if (tag.len() < 0) checks++;
`endif
    endtask

    task automatic xfer(input string tag, input bit err_any);
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        #1;
        chk({tag, "_valid_fall"}, {31'd0, sum_valid}, 32'd0);
        exp_frames++;
        if (err_any) exp_errs++;
        check_stats(tag);
    endtask

    vec_t vt[8];

    initial begin
        bit    ren_seen, drop;
        word_t w;

        vt[0] = '{64,   1'b1, 1'b0, -1, 16'd64,   32'h820,   5'b00000};
        vt[1] = '{61,   1'b1, 1'b0, -1, 16'd61,   32'h763,   5'b00000};
        vt[2] = '{16,   1'b0, 1'b0, -1, 16'd0,    32'h0,     5'b01000};
        vt[3] = '{40,   1'b1, 1'b0,  2, 16'd16,   32'h88,    5'b00010};
        vt[4] = '{1600, 1'b1, 1'b1, -1, 16'd1600, 32'h30520, 5'b10001};
        vt[5] = '{3,    1'b1, 1'b0, -1, 16'd3,    32'h6,     5'b00000};
        vt[6] = '{1518, 1'b1, 1'b0, -1, 16'd1518, 32'h2EC99, 5'b00000};
        vt[7] = '{1519, 1'b1, 1'b0, -1, 16'd1519, 32'h2ED88, 5'b00001};

        checks = 0; errors = 0; exp_frames = 0; exp_errs = 0; gidx = 0;
        reset = 1'b1; enable = 1'b1; avail = 1'b0; sum_ready = 1'b0;
        idle_word();

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ren", {31'd0, ren}, 32'd0);
        chk("rst_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_len", {16'd0, sum_len}, 32'd0);
        chk("rst_bytes", sum_bytes, 32'd0);
        chk("rst_flags", {27'd0, flags}, 32'd0);
        check_stats("rst");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            build_frame(vt[i].nbytes, vt[i].sop_first, vt[i].err_eop);
            run_frame(vt[i].stall_after, $sformatf("v%0d", i));
            check_sum($sformatf("v%0d", i), vt[i].exp_len, vt[i].exp_sum, vt[i].exp_flags);
            xfer($sformatf("v%0d", i), |vt[i].exp_flags);
        end

        // Second sop mid-frame restarts from word 2: bytes 17..32.
        build_frame(32, 1'b1, 1'b0);
        w = fq[2]; w.sop = 1'b1; fq[2] = w;
        run_frame(-1, "esop");
        check_sum("esop", 16'd16, 32'h188, 5'b00100);
        xfer("esop", 1'b1);

        // enable low keeps the drain parked in IDLE despite avail.
        enable = 1'b0; avail = 1'b1; ren_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #2;
            if (ren) ren_seen = 1'b1;
        end
        chk("en_low_no_ren", {31'd0, ren_seen}, 32'd0);
        enable = 1'b1;
        build_frame(8, 1'b1, 1'b0);
        run_frame(-1, "en");
        check_sum("en", 16'd8, 32'h24, 5'b00000);
        xfer("en", 1'b0);

        // Backpressure: HOLD ignores avail, next read two cycles after the transfer.
        build_frame(16, 1'b1, 1'b0);
        run_frame(-1, "bp");
        check_sum("bp", 16'd16, 32'h88, 5'b00000);
        avail = 1'b1; ren_seen = 1'b0; drop = 1'b0;
        repeat (10) begin
            @(posedge clk); #2;
            if (ren) ren_seen = 1'b1;
            if (!sum_valid) drop = 1'b1;
        end
        chk("bp_no_ren", {31'd0, ren_seen}, 32'd0);
        chk("bp_valid_held", {31'd0, drop}, 32'd0);
        xfer("bp", 1'b0);
        chk("bp_ren_t1", {31'd0, ren}, 32'd0);
        build_frame(40, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("bp_ren_t2", {31'd0, ren}, 32'd1);
        avail = 1'b0;

        // Two words of the 40-byte frame land, then reset mid-frame.
        @(posedge clk); #1; drive_word(fq[0]); gidx = 1; #1;
        @(posedge clk); #1; drive_word(fq[1]); gidx = 2; #1;
        @(posedge clk); #1; idle_word(); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; #1;
        chk("mrst_ren", {31'd0, ren}, 32'd0);
        chk("mrst_valid", {31'd0, sum_valid}, 32'd0);
        chk("mrst_len", {16'd0, sum_len}, 32'd0);
        chk("mrst_bytes", sum_bytes, 32'd0);
        chk("mrst_flags", {27'd0, flags}, 32'd0);
        exp_frames = 0; exp_errs = 0;
        check_stats("mrst");

        // Leftover words 2..4 arrive without sop and are drained.
        run_frame(-1, "tail");
        check_sum("tail", 16'd0, 32'h0, 5'b01000);
        xfer("tail", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_rx_drain.md
# pkt_rx_drain

Packet-interface receive drain for the 10G MAC environment. It sits on the MAC's pkt_rx side, opposite the MAC's receive FIFO. It requests frames when the MAC reports `pkt_rx_avail`, reads words until end-of-packet, and checks framing. Each frame produces one summary record (byte length, byte sum, error flags) on a valid/ready output for the scoreboard or downstream logic.

## Interface
Parameters:
- `MAX_LEN`, 1518: frame length in bytes above which `sum_oversize` is set.
- `TIMEOUT`, 64: idle cycles (no `pkt_rx_val`) tolerated in READ before the frame is aborted.

Ports:
- `clk_156m25` in 1: sole clock, 156.25 MHz packet-interface clock.
- `reset_156m25` in 1: reset, synchronous, active-high.
- `enable` in 1: permits starting a new frame read.
- `pkt_rx_avail` in 1: MAC has at least one complete frame queued.
- `pkt_rx_ren` out 1: read request to the MAC.
- `pkt_rx_data` in 64: data word; first byte is in [63:56].
- `pkt_rx_val` in 1: word valid, one cycle after the `pkt_rx_ren` that requested it.
- `pkt_rx_sop` in 1, `pkt_rx_eop` in 1: frame delimiters, qualified by `pkt_rx_val`.
- `pkt_rx_mod` in 3: valid bytes in the eop word; 0 means 8.
- `pkt_rx_err` in 1: MAC-flagged bad frame, qualified by `pkt_rx_val`.
- `sum_valid` out 1, `sum_ready` in 1: summary handshake.
- `sum_len` out 16: frame byte count, saturating at 0xFFFF.
- `sum_bytes` out 32: wrap-around sum of all valid bytes.
- `sum_mac_err`, `sum_no_sop`, `sum_early_sop`, `sum_timeout`, `sum_oversize` out 1 each: error flags.
- `stat_frames`, `stat_errors` out 32: present only with `PKT_RX_DRAIN_STATS_EN`.

## Operation
- States: IDLE, READ, DISCARD, HOLD.
- **IDLE**
  - Clears the accumulators.
  - Moves to READ when `enable && pkt_rx_avail`.
- **READ**
  - `pkt_rx_ren = 1`, except it is forced to 0 combinationally in any cycle with `pkt_rx_val && pkt_rx_eop`, so no word beyond eop is requested.
  - A valid word with sop starts accumulation. The word count is reset first.
  - A valid word without sop, arriving before any sop, sets `sum_no_sop` and moves to DISCARD.
  - A valid sop arriving after accumulation has started sets `sum_early_sop`. Accumulators restart from that word.
  - A non-eop word adds 8 to length and adds its 8 bytes to the sum.
  - An eop word adds `mod==0 ? 8 : mod` bytes. Only the top `mod` bytes are summed.
  - `pkt_rx_err` on any word sets `sum_mac_err` (sticky for the frame).
  - eop moves to HOLD.
- **DISCARD**
  - Keeps `pkt_rx_ren` high and ignores data until eop.
  - eop moves to HOLD, with length and sum reported as 0.
- **Timeout**: in READ or DISCARD, a counter increments on cycles without `pkt_rx_val` and clears on a valid word. Reaching `TIMEOUT` sets `sum_timeout` and moves to HOLD.
- **Oversize**: `sum_oversize = (sum_len > MAX_LEN)`, evaluated on the final length.
- **HOLD**
  - `sum_valid = 1` with all `sum_*` stable.
  - `sum_ready` moves to IDLE.
  - `pkt_rx_avail` is ignored while in HOLD.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- `pkt_rx_ren` rises one cycle after `enable && pkt_rx_avail` is sampled high in IDLE.
- `sum_valid` rises on the cycle after the eop word (or after timeout expiry).
- Handshake: a transfer occurs on `sum_valid && sum_ready`. `sum_valid` falls the following cycle. The earliest next `pkt_rx_ren` is two cycles after the transfer (IDLE → READ).
- `enable` low does not abort a frame in progress. It only blocks leaving IDLE.
- Reset mid-frame returns to IDLE immediately. MAC words left unread are read later as a frame without sop and flagged `sum_no_sop`.
- Simultaneous sop and eop on one word is a complete one-word frame. Its length is the mod rule value.

## Configuration
- `PKT_RX_DRAIN_STATS_EN` defined:
  - `stat_frames` increments on every summary transfer.
  - `stat_errors` increments on a transfer with any error flag set.
  - Both are 32-bit wrap-around and reset to 0.
- Undefined: the stat ports and counters do not exist.

## Structure
- Shared package `pkt_rx_pkg`: state enum, summary record struct (length, sum, flag bits), and the mod-to-bytecount function.
- One sub-module `pkt_byte_acc`: per-word byte masking, length add and sum add.

## Test plan
- 64-byte frame (8 words, eop `mod=0`, bytes 0x01..0x40) → `sum_len=64`, `sum_bytes=0x820`, no flags; `pkt_rx_ren` low in the eop cycle.
- 61-byte frame (eop `mod=5`) → `sum_len=61`; bytes in [23:0] of the eop word are excluded from `sum_bytes`.
- First word without sop → `sum_no_sop=1`, `sum_len=0`, frame drained through eop.
- MAC stalls `pkt_rx_val` for 64 cycles mid-frame with `TIMEOUT=64` → `sum_timeout=1`, HOLD entered.
- 1600-byte frame with `pkt_rx_err` on the eop word → `sum_oversize=1`, `sum_mac_err=1`; with the macro defined, `stat_errors=1`.
- `sum_ready` held low for 10 cycles while `pkt_rx_avail=1` → no `pkt_rx_ren` until two cycles after the transfer; reset asserted mid-frame → all outputs 0 the next cycle.
